// File: rtl/dsp_peak_meter_multi.sv
// Multi-channel audio peak meter. It captures per-frame absolute peaks and
// clip flags, applies peak-hold with programmable hold time and shift-based
// decay, and supports a lock mode that freezes the displayed values while
// accumulation continues.
module dsp_peak_meter_multi #(
  parameter int CHN         = 2,
  parameter int WS          = 16,
  parameter int HOLD_FRAMES = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic                   iSAMPLE_STB,
  input  logic [CHN*WS-1:0]      iSAMPLES,
  input  logic                   iFRAME,
  input  logic                   iLOCK,
  output logic [CHN*(WS-1)-1:0]  oPEAK,
  output logic [CHN*(WS-1)-1:0]  oHOLD,
  output logic [CHN-1:0]         oCLIP,
  output logic                   oFRAME_STB
);

  localparam int MW = WS - 1;
  localparam int CW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_FRAMES);
  localparam logic [MW-1:0] MAG_ONE   = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] MAG_ZERO  = {MW{1'b0}};

  logic r_fs1, r_fs2, r_fs3;
  logic r_stb;
  logic w_evt;
  logic w_upd;

  // Frame events are rising edges of the synchronised frame sync; a locked
  // event is ignored for output purposes.
  assign w_evt = r_fs2 & ~r_fs3;
  assign w_upd = w_evt & ~iLOCK;
  assign oFRAME_STB = r_stb;

  // Two-flop synchroniser plus edge-detect delay; preset high so a sync that
  // is already high at reset release is not seen as an edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_fs1 <= 1'b1;
      r_fs2 <= 1'b1;
      r_fs3 <= 1'b1;
    end else begin
      r_fs1 <= iFRAME;
      r_fs2 <= r_fs1;
      r_fs3 <= r_fs2;
    end
  end

  // Output-valid strobe, high for the cycle after each unlocked update.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_stb <= 1'b0;
    end else begin
      r_stb <= w_upd;
    end
  end

  for (genvar c = 0; c < CHN; c++) begin : g_ch
    logic [WS-1:0] w_x;
    logic [MW-1:0] w_abs;
    logic [MW-1:0] w_p;
    logic [MW-1:0] w_shr;
    logic [MW-1:0] w_step;
    logic [MW-1:0] w_dec;
    logic [MW-1:0] w_hold_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_clip;
    logic          w_pclip;
    logic [MW-1:0] r_acc;
    logic [MW-1:0] r_peak;
    logic [MW-1:0] r_hold;
    logic [CW-1:0] r_cnt;
    logic          r_clipacc;
    logic          r_clip;

    assign w_x = iSAMPLES[c*WS +: WS];

    // Magnitude in WS-1 bits; the most negative code saturates to full scale.
    assign w_abs = !w_x[WS-1]                 ? w_x[MW-1:0] :
                   (w_x[MW-1:0] == MAG_ZERO)  ? {MW{1'b1}}  :
                   (~w_x[MW-1:0] + MAG_ONE);

    assign w_clip  = (w_x == {1'b0, {MW{1'b1}}}) || (w_x == {1'b1, {MW{1'b0}}});

    // Running max including a sample arriving in this very cycle.
    assign w_p     = (iSAMPLE_STB && (w_abs > r_acc)) ? w_abs : r_acc;
    assign w_pclip = r_clipacc | (iSAMPLE_STB & w_clip);

    // Decay step is a fraction of the held value but never less than one.
    assign w_shr  = r_hold >> DECAY_SHIFT;
    assign w_step = (w_shr == MAG_ZERO) ? MAG_ONE : w_shr;
    assign w_dec  = (r_hold > w_step) ? (r_hold - w_step) : MAG_ZERO;

    // Hold/decay decision for the next frame event.
    always_comb begin
      w_hold_nxt = r_hold;
      w_cnt_nxt  = r_cnt;
      if (w_p >= r_hold) begin
        w_hold_nxt = w_p;
        w_cnt_nxt  = HOLD_INIT;
      end else if (r_cnt != {CW{1'b0}}) begin
        w_cnt_nxt  = r_cnt - CW'(1'b1);
      end else begin
        w_hold_nxt = (w_dec > w_p) ? w_dec : w_p;
      end
    end

    // Per-channel accumulation and frame-boundary publication.
    always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
        r_acc     <= MAG_ZERO;
        r_clipacc <= 1'b0;
        r_peak    <= MAG_ZERO;
        r_clip    <= 1'b0;
        r_hold    <= MAG_ZERO;
        r_cnt     <= {CW{1'b0}};
      end else if (w_upd) begin
        r_peak    <= w_p;
        r_clip    <= w_pclip;
        r_acc     <= MAG_ZERO;
        r_clipacc <= 1'b0;
        r_hold    <= w_hold_nxt;
        r_cnt     <= w_cnt_nxt;
      end else if (iSAMPLE_STB) begin
        r_acc     <= w_p;
        r_clipacc <= w_pclip;
      end
    end

    assign oPEAK[c*MW +: MW] = r_peak;
    assign oHOLD[c*MW +: MW] = r_hold;
    assign oCLIP[c]          = r_clip;
  end

endmodule
